// File: rtl/bcd_tick_counter_pkg.sv
// Shared types and constants for the BCD tick counter: control-FSM state
// encoding and BCD digit limits.
package bcd_tick_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   // Non-decimal nibbles collapse to zero so the count stays valid BCD.
   function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] n);
      return (n > BCD_MAX) ? BCD_MIN : n;
   endfunction

endpackage

// File: rtl/bcd_tick_counter_digit.sv
// One BCD digit: clear/load/step with a combinational carry (up) or borrow
// (down) flag that tells the next digit this one is about to roll over.
module bcd_digit
   import bcd_tick_counter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic               step,
   input  logic               dir,
   output logic [DIGIT_W-1:0] q,
   output logic               cb_c
);

   logic [DIGIT_W-1:0] q_q;
   logic [DIGIT_W-1:0] q_d;

   assign cb_c = dir ? (q_q == BCD_MIN) : (q_q == BCD_MAX);
   assign q    = q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = BCD_MIN;
      end else if (ld) begin
         q_d = bcd_sanitize(ld_val);
      end else if (step) begin
         if (dir) begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : DIGIT_W'(q_q - 4'd1);
         end else begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : DIGIT_W'(q_q + 4'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= BCD_MIN;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/bcd_tick_counter.sv
// Tick consumer: start/stop/clear control FSM gating the tick generator, and
// an NDIG-digit up/down BCD counter with parallel load and a wrap pulse.
module bcd_tick_counter
   import bcd_tick_counter_pkg::*;
#(
   parameter int unsigned NDIG    = 4,
   parameter bit          LOAD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              dir,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
   input  logic              tick_in,
   output logic              timer_en,
   output logic [4*NDIG-1:0] count,
   output logic              wrap,
   output logic              running
);

   state_e state_q;
   state_e state_d;
   logic   run_q;
   logic   wrap_q;
   logic   wrap_d;

   logic            ld_c;
   logic            accept_c;
   logic [NDIG-1:0] step_c;
   logic [NDIG-1:0] cb_c;

   // Clear and load both swallow a coincident tick.
   assign ld_c     = LOAD_EN && load;
   assign accept_c = (state_q == ST_RUN) && tick_in && !clear && !ld_c;

   assign step_c[0] = accept_c;

   for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      if (gi > 0) begin : g_chain
         assign step_c[gi] = step_c[gi-1] & cb_c[gi-1];
      end
      bcd_digit u_digit (
         .clk    (clk),
         .rst    (rst),
         .clr    (clear),
         .ld     (ld_c),
         .ld_val (load_val[gi*DIGIT_W +: DIGIT_W]),
         .step   (step_c[gi]),
         .dir    (dir),
         .q      (count[gi*DIGIT_W +: DIGIT_W]),
         .cb_c   (cb_c[gi])
      );
   end

   // Next state: clear beats load, load freezes state, stop beats start.
   always_comb begin
      state_d = state_q;
      wrap_d  = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
      end else if (!ld_c) begin
         case (state_q)
            ST_IDLE:  if (start && !stop) state_d = ST_RUN;
            ST_RUN:   if (stop)           state_d = ST_PAUSE;
            ST_PAUSE: if (start && !stop) state_d = ST_RUN;
            default:                      state_d = ST_IDLE;
         endcase
      end
      // Every digit stepping and rolling over means a full-range wrap.
      wrap_d = step_c[NDIG-1] & cb_c[NDIG-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= (state_d == ST_RUN);
         wrap_q  <= wrap_d;
      end
   end

   assign timer_en = run_q;
   assign running  = run_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter: directed scenarios plus random
// traffic, all checked against an integer-valued behavioural model.
module tb_bcd_tick_counter;

   localparam int unsigned NDIG = 4;
   localparam int          MOD  = 10000;

   logic        clk = 1'b0;
   logic        rst, start, stop, clear, dir, load, tick_in;
   logic [15:0] load_val;
   logic        timer_en, wrap, running;
   logic [15:0] count;

   int n_cmp = 0;
   int n_err = 0;

   // Model: 0 idle, 1 run, 2 pause; count held as a plain integer.
   int m_state = 0;
   int m_count = 0;
   bit m_wrap  = 1'b0;

   bcd_tick_counter #(.NDIG(NDIG), .LOAD_EN(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .tick_in  (tick_in),
      .timer_en (timer_en),
      .count    (count),
      .wrap     (wrap),
      .running  (running)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int load_value(input logic [15:0] lv);
      int v, w;
      logic [3:0] n;
      v = 0;
      w = 1;
      for (int i = 0; i < 4; i++) begin
         n = lv[i*4 +: 4];
         v = v + ((n > 4'd9) ? 0 : int'(n)) * w;
         w = w * 10;
      end
      return v;
   endfunction

   // Drive one cycle of inputs, advance the model, step past the clock edge.
   task automatic step(input logic r, input logic s, input logic p, input logic c,
                       input logic d, input logic l, input logic [15:0] lv,
                       input logic t);
      bit acc;
      rst = r; start = s; stop = p; clear = c; dir = d; load = l;
      load_val = lv; tick_in = t;
      acc = (m_state == 1) && t && !c && !l;
      if (r) begin
         m_state = 0; m_count = 0; m_wrap = 0;
      end else if (c) begin
         m_state = 0; m_count = 0; m_wrap = 0;
      end else if (l) begin
         m_count = load_value(lv); m_wrap = 0;
      end else begin
         m_wrap = 0;
         if (acc) begin
            if (!d) begin
               m_wrap  = (m_count == MOD - 1);
               m_count = (m_count + 1) % MOD;
            end else begin
               m_wrap  = (m_count == 0);
               m_count = (m_count + MOD - 1) % MOD;
            end
         end
         if (m_state == 0 && s && !p) m_state = 1;
         else if (m_state == 1 && p) m_state = 2;
         else if (m_state == 2 && s && !p) m_state = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic d);
      step(0, 0, 0, 0, d, 0, 16'h0, 0);
   endtask

   task automatic test_reset;
      step(1, 0, 0, 0, 0, 0, 16'h0, 0);
      step(1, 0, 0, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0, 0, 16'h0, logic'(i % 2 == 0));
         n_cmp++;
         if (count !== 16'h0000 || timer_en !== 1'b0 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle cyc=%0d: count=%h en=%b wrap=%b, want 0000/0/0",
                     i, count, timer_en, wrap);
         end
      end
   endtask

   task automatic test_basic_run;
      step(0, 1, 0, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (timer_en !== 1'b1 || running !== 1'b1) begin
         n_err++;
         $display("FAIL run_enable: en=%b running=%b, want 1/1", timer_en, running);
      end
      for (int i = 1; i <= 12; i++) begin
         step(0, 0, 0, 0, 0, 0, 16'h0, 1);
         n_cmp++;
         if (count !== to_bcd(i) || count !== to_bcd(m_count)) begin
            n_err++;
            $display("FAIL run_tick%0d: count=%h, want %h", i, count, to_bcd(i));
         end
         idle(0);
      end
      n_cmp++;
      if (count !== 16'h0012) begin
         n_err++;
         $display("FAIL run_final: count=%h, want 0012", count);
      end
   endtask

   task automatic test_pause_resume;
      step(0, 0, 1, 0, 0, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h0013 || timer_en !== 1'b0 || running !== 1'b0) begin
         n_err++;
         $display("FAIL stop_tick: count=%h en=%b run=%b, want 0013/0/0",
                  count, timer_en, running);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 16'h0, 1);
         n_cmp++;
         if (count !== 16'h0013 || timer_en !== 1'b0) begin
            n_err++;
            $display("FAIL paused_tick%0d: count=%h en=%b, want 0013/0", i, count, timer_en);
         end
      end
      step(0, 1, 0, 0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 0, 0, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h0014 || timer_en !== 1'b1) begin
         n_err++;
         $display("FAIL resume: count=%h en=%b, want 0014/1", count, timer_en);
      end
   endtask

   task automatic test_up_wrap;
      step(0, 0, 0, 0, 0, 1, 16'h9998, 0);
      n_cmp++;
      if (count !== 16'h9998 || running !== 1'b1) begin
         n_err++;
         $display("FAIL load_9998: count=%h run=%b, want 9998/1", count, running);
      end
      step(0, 0, 0, 0, 0, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h9999 || wrap !== 1'b0) begin
         n_err++;
         $display("FAIL up_9999: count=%h wrap=%b, want 9999/0", count, wrap);
      end
      step(0, 0, 0, 0, 0, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h0000 || wrap !== 1'b1) begin
         n_err++;
         $display("FAIL up_wrap: count=%h wrap=%b, want 0000/1", count, wrap);
      end
      idle(0);
      n_cmp++;
      if (wrap !== 1'b0) begin
         n_err++;
         $display("FAIL up_wrap_len: wrap=%b, want 0", wrap);
      end
   endtask

   task automatic test_down_wrap;
      step(0, 0, 0, 0, 1, 1, 16'h0100, 0);
      step(0, 0, 0, 0, 1, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h0099 || wrap !== 1'b0) begin
         n_err++;
         $display("FAIL down_borrow: count=%h wrap=%b, want 0099/0", count, wrap);
      end
      step(0, 0, 0, 0, 1, 1, 16'h0000, 0);
      step(0, 0, 0, 0, 1, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h9999 || wrap !== 1'b1) begin
         n_err++;
         $display("FAIL down_wrap: count=%h wrap=%b, want 9999/1", count, wrap);
      end
      idle(1);
      n_cmp++;
      if (wrap !== 1'b0 || count !== 16'h9999) begin
         n_err++;
         $display("FAIL down_wrap_len: count=%h wrap=%b, want 9999/0", count, wrap);
      end
   endtask

   task automatic test_priority;
      step(0, 1, 0, 1, 0, 0, 16'h0, 1);
      n_cmp++;
      if (count !== 16'h0000 || running !== 1'b0 || timer_en !== 1'b0) begin
         n_err++;
         $display("FAIL clear_prio: count=%h run=%b, want 0000/0", count, running);
      end
      step(0, 0, 0, 0, 0, 1, 16'h00A7, 0);
      n_cmp++;
      if (count !== 16'h0007) begin
         n_err++;
         $display("FAIL load_sanitize: count=%h, want 0007", count);
      end
      step(0, 1, 1, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (running !== 1'b0) begin
         n_err++;
         $display("FAIL idle_start_stop: running=%b, want 0", running);
      end
      step(0, 1, 0, 0, 0, 1, 16'h0042, 1);
      n_cmp++;
      if (running !== 1'b0 || count !== 16'h0042) begin
         n_err++;
         $display("FAIL load_blocks_start: count=%h run=%b, want 0042/0", count, running);
      end
      step(0, 1, 0, 0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 0, 0, 1, 16'h0300, 1);
      n_cmp++;
      if (count !== 16'h0300 || running !== 1'b1) begin
         n_err++;
         $display("FAIL load_drops_tick: count=%h run=%b, want 0300/1", count, running);
      end
      step(0, 1, 1, 0, 0, 0, 16'h0, 0);
      n_cmp++;
      if (running !== 1'b0 || timer_en !== 1'b0) begin
         n_err++;
         $display("FAIL run_start_stop: run=%b en=%b, want 0/0", running, timer_en);
      end
   endtask

   task automatic test_random;
      logic d;
      logic [15:0] lv;
      d = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) d = ~d;
         lv = ($urandom_range(0, 2) == 0) ? (d ? 16'h0001 : 16'h9998) : 16'($urandom);
         step(logic'($urandom_range(0, 299) == 0),
              logic'($urandom_range(0, 7) == 0),
              logic'($urandom_range(0, 15) == 0),
              logic'($urandom_range(0, 59) == 0),
              d,
              logic'($urandom_range(0, 39) == 0),
              lv,
              logic'($urandom_range(0, 1) == 0));
         n_cmp++;
         if (count !== to_bcd(m_count) || wrap !== m_wrap ||
             running !== (m_state == 1) || timer_en !== (m_state == 1)) begin
            n_err++;
            $display("FAIL random cyc=%0d: count=%h wrap=%b run=%b en=%b, want %h/%b/%b",
                     i, count, wrap, running, timer_en, to_bcd(m_count), m_wrap,
                     (m_state == 1));
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b0;
      load = 1'b0; load_val = '0; tick_in = 1'b0;
      test_reset();
      test_basic_run();
      test_pause_resume();
      test_up_wrap();
      test_down_wrap();
      test_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
